// File: rtl/led_toggle_ctrl.sv
// led_toggle_ctrl
//   A push-button selects the LED mode. Each press moves OFF -> ON -> BLINK
//   -> CHASE -> OFF. BLINK inverts every LED after SLOW_DIV timebase ticks.
//   CHASE rotates a single lit LED left after FAST_DIV timebase ticks.
//
// Ports
//   Clk         : single clock; all state changes on its rising edge
//   Rst         : asynchronous reset, active low
//   ClkEnable   : one-cycle timebase tick (the debouncer's own tick)
//   ButtonPulse : one-cycle press pulse from the debouncer
//   LedOut      : registered LED drive, 1 = lit
//   Mode        : registered mode (00 OFF, 01 ON, 10 BLINK, 11 CHASE)
//   StepPulse   : registered one-cycle pulse on each BLINK toggle or CHASE shift
module led_toggle_ctrl #(
  parameter int NUM_LEDS = 8,
  parameter int SLOW_DIV = 500,
  parameter int FAST_DIV = 125
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                ClkEnable,
  input  logic                ButtonPulse,
  output logic [NUM_LEDS-1:0] LedOut,
  output logic [1:0]          Mode,
  output logic                StepPulse
);

  localparam int MaxDiv   = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CntWidth = $clog2(MaxDiv + 1);

  localparam logic [CntWidth-1:0] SlowLast = CntWidth'(SLOW_DIV - 1);
  localparam logic [CntWidth-1:0] FastLast = CntWidth'(FAST_DIV - 1);
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
  localparam logic [NUM_LEDS-1:0] LedOne   = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    ModeOff   = 2'b00,
    ModeOn    = 2'b01,
    ModeBlink = 2'b10,
    ModeChase = 2'b11
  } modeT;

  modeT                modeQ, modeD;
  logic [NUM_LEDS-1:0] ledQ, ledD;
  logic [CntWidth-1:0] cntQ, cntD;
  logic                stepQ, stepD;

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      modeQ <= ModeOff;
      ledQ  <= '0;
      cntQ  <= '0;
      stepQ <= 1'b0;
    end else begin
      modeQ <= modeD;
      ledQ  <= ledD;
      cntQ  <= cntD;
      stepQ <= stepD;
    end
  end

  // Next-state logic: every cycle with a press advances one mode,
  // so a held pulse steps through several modes.
  always_comb begin
    modeD = modeQ;
    if (ButtonPulse) begin
      unique case (modeQ)
        ModeOff:   modeD = ModeOn;
        ModeOn:    modeD = ModeBlink;
        ModeBlink: modeD = ModeChase;
        ModeChase: modeD = ModeOff;
      endcase
    end
  end

  // Output/datapath logic. A press takes priority over a due step: the
  // step is dropped and the entry pattern of the new mode is loaded.
  always_comb begin
    ledD  = ledQ;
    cntD  = cntQ;
    stepD = 1'b0;
    if (ButtonPulse) begin
      cntD = '0;
      unique case (modeD)
        ModeOff:   ledD = '0;
        ModeOn:    ledD = '1;
        ModeBlink: ledD = '1;
        ModeChase: ledD = LedOne;
      endcase
    end else begin
      unique case (modeQ)
        ModeOff: begin
          ledD = '0;
          cntD = '0;
        end
        ModeOn: begin
          ledD = '1;
          cntD = '0;
        end
        ModeBlink: begin
          if (ClkEnable) begin
            if (cntQ == SlowLast) begin
              cntD  = '0;
              ledD  = ~ledQ;
              stepD = 1'b1;
            end else begin
              cntD = cntQ + CntOne;
            end
          end
        end
        ModeChase: begin
          if (ClkEnable) begin
            if (cntQ == FastLast) begin
              cntD  = '0;
              ledD  = {ledQ[NUM_LEDS-2:0], ledQ[NUM_LEDS-1]};
              stepD = 1'b1;
            end else begin
              cntD = cntQ + CntOne;
            end
          end
        end
      endcase
    end
  end

  assign Mode      = modeQ;
  assign LedOut    = ledQ;
  assign StepPulse = stepQ;

endmodule

// File: tb/tb_led_toggle_ctrl.sv
// tb_led_toggle_ctrl
//   Scoreboard bench for led_toggle_ctrl with NUM_LEDS=4, SLOW_DIV=3,
//   FAST_DIV=2. A behavioural model predicts each cycle's outputs when the
//   stimulus is driven. The prediction is queued, then popped and compared
//   one edge later.
module tb_led_toggle_ctrl;

  localparam int NumLeds = 4;
  localparam int SlowDiv = 3;
  localparam int FastDiv = 2;

  logic               Clk;
  logic               Rst;
  logic               ClkEnable;
  logic               ButtonPulse;
  logic [NumLeds-1:0] LedOut;
  logic [1:0]         Mode;
  logic               StepPulse;

  typedef struct packed {
    logic [1:0]         mode;
    logic [NumLeds-1:0] led;
    logic               step;
  } expT;

  expT sbQueue[$];

  int checkCount = 0;
  int errorCount = 0;

  // Model state
  logic [1:0]         mMode;
  logic [NumLeds-1:0] mLed;
  int                 mTicks;

  led_toggle_ctrl #(
    .NUM_LEDS(NumLeds),
    .SLOW_DIV(SlowDiv),
    .FAST_DIV(FastDiv)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .ClkEnable(ClkEnable),
    .ButtonPulse(ButtonPulse),
    .LedOut(LedOut),
    .Mode(Mode),
    .StepPulse(StepPulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mMode  = 2'b00;
    mLed   = '0;
    mTicks = 0;
  endtask

  // Drive one cycle of inputs, predict the result, then compare it after the edge.
  task automatic applyStimulus(input string tag, input logic bp, input logic ce);
    expT exp;
    expT got;
    int  div;
    ButtonPulse = bp;
    ClkEnable   = ce;
    exp.step = 1'b0;
    if (bp) begin
      mMode  = mMode + 2'd1;
      mTicks = 0;
      case (mMode)
        2'b00:          mLed = 4'b0000;
        2'b01, 2'b10:   mLed = 4'b1111;
        default:        mLed = 4'b0001;
      endcase
    end else if (mMode[1]) begin
      if (ce) begin
        mTicks++;
        div = (mMode == 2'b10) ? SlowDiv : FastDiv;
        if (mTicks == div) begin
          mTicks   = 0;
          exp.step = 1'b1;
          if (mMode == 2'b10) mLed = ~mLed;
          else                mLed = {mLed[NumLeds-2:0], mLed[NumLeds-1]};
        end
      end
    end else begin
      mTicks = 0;
    end
    exp.mode = mMode;
    exp.led  = mLed;
    sbQueue.push_back(exp);
    @(posedge Clk);
    #1;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      got = sbQueue.pop_front();
      checkOutput({tag, "_mode"}, 32'(Mode), 32'(got.mode));
      checkOutput({tag, "_led"},  32'(LedOut), 32'(got.led));
      checkOutput({tag, "_step"}, 32'(StepPulse), 32'(got.step));
    end
  endtask

  logic [1:0] req030Mode [4];
  logic [3:0] req030Led  [4];

  initial begin
    req030Mode = '{2'b01, 2'b10, 2'b11, 2'b00};
    req030Led  = '{4'b1111, 4'b1111, 4'b0001, 4'b0000};

    // Reset must act without a clock edge
    Rst = 1'b0;
    ButtonPulse = 1'b0;
    ClkEnable = 1'b0;
    modelReset();
    #1;
    checkOutput("resetMode", 32'(Mode), 32'd0);
    checkOutput("resetLed", 32'(LedOut), 32'd0);
    checkOutput("resetStep", 32'(StepPulse), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // Single presses 10 cycles apart, no timebase
    for (int i = 0; i < 4; i++) begin
      applyStimulus("req030Press", 1'b1, 1'b0);
      checkOutput("req030ModeTbl", 32'(Mode), 32'(req030Mode[i]));
      checkOutput("req030LedTbl", 32'(LedOut), 32'(req030Led[i]));
      for (int j = 0; j < 9; j++) applyStimulus("req030Idle", 1'b0, 1'b0);
    end

    // Held button from OFF walks three modes
    for (int i = 0; i < 3; i++) applyStimulus("req035Hold", 1'b1, 1'b0);
    checkOutput("req035Mode", 32'(Mode), 32'd3);
    checkOutput("req035Led", 32'(LedOut), 32'd1);
    applyStimulus("req035Release", 1'b0, 1'b0);

    // CHASE -> OFF -> ON -> BLINK, then blink with tick every cycle
    for (int i = 0; i < 3; i++) applyStimulus("toBlink", 1'b1, 1'b0);
    checkOutput("blinkEntryMode", 32'(Mode), 32'd2);
    for (int i = 0; i < 9; i++) begin
      applyStimulus("req031Blink", 1'b0, 1'b1);
      if (i == 2) checkOutput("req031FirstToggle", 32'(LedOut), 32'h0);
      if (i == 5) checkOutput("req031SecondToggle", 32'(LedOut), 32'hF);
    end

    // BLINK -> CHASE, tick every other cycle for 16 cycles
    applyStimulus("toChase", 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus("req032Chase", 1'b0, (i % 2) == 0);
      if (i == 3)  checkOutput("req032Shift1", 32'(LedOut), 32'b0010);
      if (i == 11) checkOutput("req032Shift3", 32'(LedOut), 32'b1000);
    end
    checkOutput("req032Wrap", 32'(LedOut), 32'b0001);

    // Counter at 1, press coincides with a due step: press wins
    applyStimulus("req033Prime", 1'b0, 1'b1);
    applyStimulus("req033Collide", 1'b1, 1'b1);
    checkOutput("req033Mode", 32'(Mode), 32'd0);
    checkOutput("req033Led", 32'(LedOut), 32'd0);
    checkOutput("req033Step", 32'(StepPulse), 32'd0);

    // Reach CHASE with pattern 0100, then assert reset between edges
    for (int i = 0; i < 3; i++) applyStimulus("toChase2", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("req034Run", 1'b0, 1'b1);
    checkOutput("req034Pattern", 32'(LedOut), 32'b0100);
    #2;
    Rst = 1'b0;
    modelReset();
    #1;
    checkOutput("req034AsyncMode", 32'(Mode), 32'd0);
    checkOutput("req034AsyncLed", 32'(LedOut), 32'd0);
    ButtonPulse = 1'b1;
    ClkEnable = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("req028HeldMode", 32'(Mode), 32'd0);
    checkOutput("req028HeldLed", 32'(LedOut), 32'd0);
    checkOutput("req028HeldStep", 32'(StepPulse), 32'd0);
    ButtonPulse = 1'b0;
    ClkEnable = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    applyStimulus("req034After", 1'b1, 1'b0);
    checkOutput("req034AfterMode", 32'(Mode), 32'd1);
    checkOutput("req034AfterLed", 32'(LedOut), 32'hF);

    // Random mix of presses and ticks
    for (int i = 0; i < 300; i++) begin
      applyStimulus("random", $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/led_toggle_ctrl.md
LED_TOGGLE_CTRL -- requirements
Module: led_toggle_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8: LED output width; legal range >= 2.
REQ-002 The block SHALL have parameter SLOW_DIV, default 500: ClkEnable ticks per BLINK half-period; legal range >= 1.
REQ-003 The block SHALL have parameter FAST_DIV, default 125: ClkEnable ticks per CHASE step; legal range >= 1.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ClkEnable, input, 1 bit: one-Clk-cycle timebase tick, the same tick that feeds the button debouncer.
REQ-007 The block SHALL have port ButtonPulse, input, 1 bit: one-cycle press pulse from the debouncer output.
REQ-008 The block SHALL have port LedOut, output, NUM_LEDS bits: registered LED drive, 1 = lit.
REQ-009 The block SHALL have port Mode, output, 2 bits: registered current mode encoding.
REQ-010 The block SHALL have port StepPulse, output, 1 bit: registered one-cycle pulse on each BLINK toggle or CHASE shift.

Function
REQ-011 Modes SHALL be: OFF=2'b00, ON=2'b01, BLINK=2'b10, CHASE=2'b11.
REQ-012 Each Clk cycle with ButtonPulse=1 SHALL advance the mode OFF->ON->BLINK->CHASE->OFF; ButtonPulse high for k consecutive cycles advances k steps, with no edge detection in this block.
REQ-013 Mode, LedOut and StepPulse SHALL update on the same edge that samples ButtonPulse=1: one-edge latency, no combinational input-to-output path.
REQ-014 In OFF, LedOut SHALL be all 0; in ON, LedOut SHALL be all 1.
REQ-015 On entry to BLINK, LedOut SHALL be all 1; thereafter every SLOW_DIV ClkEnable ticks LedOut SHALL invert (all 1 <-> all 0).
REQ-016 On entry to CHASE, LedOut SHALL be 1 (bit0 only); thereafter every FAST_DIV ClkEnable ticks LedOut SHALL rotate left by one, with bit NUM_LEDS-1 wrapping to bit0.
REQ-017 Tick counter width SHALL be ceil(log2(max(SLOW_DIV,FAST_DIV)+1)).
REQ-018 In BLINK/CHASE, the counter SHALL increment on ClkEnable=1.
REQ-019 When ClkEnable=1 and the counter equals DIV-1 for the active mode, the counter SHALL clear to 0 and a step SHALL occur.
REQ-020 With DIV=1, a step SHALL occur on every ClkEnable.
REQ-021 The counter SHALL hold when ClkEnable=0, and SHALL be held at 0 in OFF and ON.
REQ-022 Every mode change SHALL clear the counter to 0.
REQ-023 StepPulse SHALL be 1 for exactly the one cycle following the edge on which a step occurs, else 0; it SHALL never assert in OFF or ON.
REQ-024 When ButtonPulse=1 and a step are due on the same edge, the mode change SHALL win: the step is discarded, StepPulse stays 0, and the new mode's entry pattern is loaded.
REQ-025 The wrap from CHASE to OFF SHALL clear LedOut to 0 on that edge.

Reset
REQ-026 Rst=0 SHALL immediately, without waiting for Clk, force Mode=OFF, LedOut=0, StepPulse=0, counter=0.
REQ-027 Rst=0 asserted mid-BLINK or mid-CHASE SHALL discard all phase and pattern state; the first operation after release starts from OFF.
REQ-028 While Rst=0, ButtonPulse and ClkEnable SHALL be ignored.
REQ-029 The first rising Clk edge after Rst returns high SHALL process inputs normally.

Verification
Bench parameters: NUM_LEDS=4, SLOW_DIV=3, FAST_DIV=2.
REQ-030 Reset then 4 single ButtonPulses 10 cycles apart with ClkEnable=0 -> Mode 01,10,11,00; LedOut 1111,1111,0001,0000; StepPulse never 1.
REQ-031 BLINK with ClkEnable=1 every cycle for 9 cycles -> LedOut 1111 for 3 cycles, then 0000 for 3, then 1111; StepPulse high at cycles 4 and 7 after entry.
REQ-032 CHASE with ClkEnable every other cycle for 16 cycles -> LedOut 0001,0010,0100,1000,0001, one shift every 4 Clk cycles, wrap verified.
REQ-033 CHASE with counter at 1 and ButtonPulse coinciding with ClkEnable -> Mode=00, LedOut=0000, StepPulse=0.
REQ-034 Rst driven low between Clk edges during CHASE (LedOut=0100) -> outputs 0/OFF before the next Clk edge; after release, one ButtonPulse gives Mode=01, LedOut=1111.
REQ-035 ButtonPulse held high 3 consecutive cycles from OFF -> Mode 01,10,11 on successive edges, ending with LedOut=0001.
